// File: rtl/mem_access_sequencer_if.sv
// Data bus between the load/store sequencer and external memory.
// The master issues req/we/addr/wdata/be; the slave answers ack/err/rdata.
interface mem_access_sequencer_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_wdata, bus_be,
    input  bus_ack, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_wdata, bus_be,
    output bus_ack, bus_rdata, bus_err
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store sequencer: legality check, req/ack bus
// transaction, lane strobes, load extension and one-cycle fault pulses.
module mem_access_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_enable,
  input  logic        mem_rw_mode,
  input  logic [2:0]  mem_func,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  mem_access_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, REQ, DONE, FAULT
  } state_t;

  localparam int CW =
    (TIMEOUT_CYCLES < 2) ? 1 :
    $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX =
    CW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          latch;

  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic [2:0]    func_q;
  logic [1:0]    off_q;

  logic          legal, aligned;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [31:0]   ld;

  // Request decode: legality, alignment, lanes, replicated store data
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    be_n    = 4'b0000;
    wd_n    = 32'h0;
    case (mem_func)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !mem_rw_mode;
      default:                legal = 1'b0;
    endcase
    case (mem_func[1:0])
      2'b00: begin
        aligned = 1'b1;
        be_n    = 4'b0001 << addr[1:0];
        wd_n    = {4{wdata[7:0]}};
      end
      2'b01: begin
        aligned = !addr[0];
        be_n    = addr[1] ? 4'b1100 : 4'b0011;
        wd_n    = {2{wdata[15:0]}};
      end
      default: begin
        aligned = (addr[1:0] == 2'b00);
        be_n    = 4'b1111;
        wd_n    = wdata;
      end
    endcase
    if (!mem_rw_mode)
      wd_n = 32'h0;
  end

  // Load lane extraction from the returned word
  always_comb begin
    lb = 8'h0;
    lh = off_q[1] ? bus.bus_rdata[31:16]
                  : bus.bus_rdata[15:0];
    case (off_q)
      2'd0:    lb = bus.bus_rdata[7:0];
      2'd1:    lb = bus.bus_rdata[15:8];
      2'd2:    lb = bus.bus_rdata[23:16];
      default: lb = bus.bus_rdata[31:24];
    endcase
    case (func_q)
      3'b000:  ld = {{24{lb[7]}}, lb};
      3'b001:  ld = {{16{lh[15]}}, lh};
      3'b100:  ld = {24'h0, lb};
      3'b101:  ld = {16'h0, lh};
      default: ld = bus.bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    rdata_d = rdata_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_enable) begin
          if (!legal) begin
            state_d = FAULT;
            cause_d = 2'b01;
          end else if (!aligned) begin
            state_d = FAULT;
            cause_d = 2'b00;
          end else begin
            state_d = REQ;
            latch   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        if (bus.bus_err) begin
          state_d = FAULT;
          cause_d = 2'b10;
        end else if (bus.bus_ack) begin
          state_d = DONE;
          if (!we_q)
            rdata_d = ld;
        end else if (TO_EN &&
                     cnt_q == TO_MAX - 1'b1) begin
          state_d = FAULT;
          cause_d = 2'b11;
          cnt_d   = TO_MAX;
        end else if (TO_EN && cnt_q != TO_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cause_q <= 2'b00;
      rdata_q <= 32'h0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      func_q  <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
      if (latch) begin
        we_q    <= mem_rw_mode;
        addr_q  <= {addr[31:2], 2'b00};
        wdata_q <= wd_n;
        be_q    <= be_n;
        func_q  <= mem_func;
        off_q   <= addr[1:0];
      end
    end
  end

  assign stall = (state_q == IDLE && mem_enable) ||
                 (state_q == REQ);
  assign done        = (state_q == DONE);
  assign fault       = (state_q == FAULT);
  assign fault_cause = cause_q;
  assign rdata       = rdata_q;

  assign bus.bus_req   = (state_q == REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_be    = be_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer with a scripted bus slave.
// Timeout parameter is 4 so the timeout path is reachable quickly.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_enable, mem_rw_mode;
  logic [2:0]  mem_func;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic [1:0]  fault_cause;

  mem_access_sequencer_if bus ();

  mem_access_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_enable(mem_enable), .mem_rw_mode(mem_rw_mode),
    .mem_func(mem_func), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata),
    .fault(fault), .fault_cause(fault_cause),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    logic [1:0]  cause;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  int          o_stall, o_req;
  bit          o_done, o_fault, o_unstable, o_after;
  logic        o_we;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_be;
  logic [1:0]  o_cause;
  logic [31:0] last_rd;

  function automatic logic [31:0] model_load(
    input logic [2:0] f, input logic [1:0] off,
    input logic [31:0] rd);
    logic [31:0] sb, sh;
    sb = rd >> (8 * off);
    sh = rd >> (16 * off[1]);
    case (f)
      3'b000:  return {{24{sb[7]}}, sb[7:0]};
      3'b100:  return {24'h0, sb[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  // Drives one operation and acts as the bus slave; ack_at=0 never acks
  task automatic run_op(input bit rw, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input bit err,
                        input logic [31:0] rd);
    o_stall = 0; o_req = 0; o_done = 0; o_fault = 0;
    o_unstable = 0; o_after = 0;
    o_we = 0; o_addr = 0; o_wdata = 0; o_be = 0;
    @(negedge clk);
    mem_enable = 1'b1; mem_rw_mode = rw;
    mem_func = f; addr = a; wdata = wd;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall) o_stall++;
      if (done)  o_done = 1;
      if (fault) o_fault = 1;
      if (bus.bus_req) begin
        o_req++;
        if (o_req == 1) begin
          o_we = bus.bus_we; o_addr = bus.bus_addr;
          o_wdata = bus.bus_wdata; o_be = bus.bus_be;
        end else if ({o_we, o_addr, o_wdata, o_be} !==
                     {bus.bus_we, bus.bus_addr,
                      bus.bus_wdata, bus.bus_be}) begin
          o_unstable = 1;
        end
      end
      bus.bus_ack   = bus.bus_req && ack_at != 0 && o_req == ack_at;
      bus.bus_err   = bus.bus_req && err && o_req == ack_at;
      bus.bus_rdata = rd;
      o_rdata = rdata;
      o_cause = fault_cause;
      if (done || fault) break;
      @(negedge clk);
      mem_enable = 1'b0;
    end
    bus.bus_ack = 1'b0;
    bus.bus_err = 1'b0;
    mem_enable  = 1'b0;
    @(negedge clk);
    #1;
    o_after = done | fault;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_enable = 0; mem_rw_mode = 0; mem_func = 0;
    addr = 0; wdata = 0;
    bus.bus_ack = 0; bus.bus_err = 0; bus.bus_rdata = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({stall, done, fault, bus.bus_req, bus.bus_we} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctl got %b want 00000",
               {stall, done, fault, bus.bus_req, bus.bus_we});
    end
    n_cmp++;
    if ({fault_cause, rdata} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_rdata got %h/%h want 0/0",
               fault_cause, rdata);
    end
    n_cmp++;
    if ({bus.bus_addr, bus.bus_wdata, bus.bus_be} !== 68'h0) begin
      n_err++;
      $display("FAIL reset_bus got %h %h %h want 0",
               bus.bus_addr, bus.bus_wdata, bus.bus_be);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    exp_q.push_back('{0, 2'b00, 32'hDEADBEEF});
    run_op(0, 3'b010, 32'h100, 32'h0, 3, 0, 32'hDEADBEEF);
    n_cmp++;
    if ({o_addr, o_be, o_we, o_wdata} !==
        {32'h100, 4'b1111, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL lw_bus got %h %b %b %h want 100 1111 0 0",
               o_addr, o_be, o_we, o_wdata);
    end
    n_cmp++;
    if (o_stall !== 4 || o_req !== 3 || o_unstable) begin
      n_err++;
      $display("FAIL lw_timing got stall=%0d req=%0d unst=%0d want 4 3 0",
               o_stall, o_req, o_unstable);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (!o_done || o_fault || o_rdata !== e.rdata || o_after) begin
      n_err++;
      $display("FAIL lw_result got done=%0d fault=%0d rdata=%h after=%0d want 1 0 %h 0",
               o_done, o_fault, o_rdata, o_after, e.rdata);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f[3]  = '{3'b000, 3'b100, 3'b101};
    logic [31:0] a[3]  = '{32'h203, 32'h203, 32'h202};
    logic [31:0] r[3]  = '{32'hFFFFFF80, 32'h80, 32'h80FF};
    logic [3:0]  b[3]  = '{4'b1000, 4'b1000, 4'b1100};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{0, 2'b00, r[i]});
      run_op(0, f[i], a[i], 32'h0, 1, 0, 32'h80FF1234);
      n_cmp++;
      if (o_be !== b[i] || o_addr !== 32'h200 || o_stall !== 2) begin
        n_err++;
        $display("FAIL ext_bus[%0d] got be=%b addr=%h stall=%0d want %b 200 2",
                 i, o_be, o_addr, o_stall, b[i]);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (!o_done || o_rdata !== e.rdata) begin
        n_err++;
        $display("FAIL ext_rdata[%0d] got %h done=%0d want %h",
                 i, o_rdata, o_done, e.rdata);
      end
    end
    last_rd = 32'h80FF;
  endtask

  task automatic test_store();
    exp_q.push_back('{0, 2'b00, last_rd});
    run_op(1, 3'b001, 32'h102, 32'h0000ABCD, 2, 0, 32'h0);
    n_cmp++;
    if ({o_addr, o_be, o_we, o_wdata} !==
        {32'h100, 4'b1100, 1'b1, 32'hABCDABCD}) begin
      n_err++;
      $display("FAIL sh_bus got %h %b %b %h want 100 1100 1 abcdabcd",
               o_addr, o_be, o_we, o_wdata);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (!o_done || o_rdata !== e.rdata) begin
      n_err++;
      $display("FAIL sh_result got done=%0d rdata=%h want 1 %h",
               o_done, o_rdata, e.rdata);
    end
    exp_q.push_back('{0, 2'b00, last_rd});
    run_op(1, 3'b000, 32'h101, 32'h55667712, 1, 0, 32'h0);
    e = exp_q.pop_front();
    n_cmp++;
    if (o_be !== 4'b0010 || o_wdata !== 32'h12121212 ||
        !o_done || o_rdata !== e.rdata) begin
      n_err++;
      $display("FAIL sb got be=%b wd=%h done=%0d rd=%h want 0010 12121212 1 %h",
               o_be, o_wdata, o_done, o_rdata, e.rdata);
    end
    exp_q.push_back('{0, 2'b00, last_rd});
    run_op(1, 3'b010, 32'h10C, 32'h89ABCDEF, 1, 0, 32'h0);
    e = exp_q.pop_front();
    n_cmp++;
    if (o_be !== 4'b1111 || o_wdata !== 32'h89ABCDEF ||
        o_addr !== 32'h10C || o_rdata !== e.rdata) begin
      n_err++;
      $display("FAIL sw got be=%b wd=%h a=%h rd=%h want 1111 89abcdef 10c %h",
               o_be, o_wdata, o_addr, o_rdata, e.rdata);
    end
  endtask

  task automatic test_faults();
    logic        rw[3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]  f[3]  = '{3'b010, 3'b100, 3'b101};
    logic [31:0] a[3]  = '{32'h102, 32'h100, 32'h101};
    logic [1:0]  c[3]  = '{2'b00, 2'b01, 2'b01};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{1, c[i], last_rd});
      run_op(rw[i], f[i], a[i], 32'h1, 1, 0, 32'h0);
      e = exp_q.pop_front();
      n_cmp++;
      if (!o_fault || o_done || o_cause !== e.cause ||
          o_req !== 0 || o_stall !== 1) begin
        n_err++;
        $display("FAIL fault[%0d] got f=%0d d=%0d c=%b req=%0d st=%0d want 1 0 %b 0 1",
                 i, o_fault, o_done, o_cause, o_req, o_stall, e.cause);
      end
      n_cmp++;
      if (o_rdata !== e.rdata || o_after) begin
        n_err++;
        $display("FAIL fault_side[%0d] got rd=%h after=%0d want %h 0",
                 i, o_rdata, o_after, e.rdata);
      end
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back('{1, 2'b11, last_rd});
    run_op(0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_cmp++;
    if (o_req !== 4 || o_stall !== 5 || o_unstable) begin
      n_err++;
      $display("FAIL timeout_len got req=%0d stall=%0d want 4 5",
               o_req, o_stall);
    end
    n_cmp++;
    if (!o_fault || o_cause !== e.cause || o_rdata !== e.rdata) begin
      n_err++;
      $display("FAIL timeout_cause got f=%0d c=%b rd=%h want 1 %b %h",
               o_fault, o_cause, o_rdata, e.cause, e.rdata);
    end
    n_cmp++;
    if (fault_cause !== e.cause) begin
      n_err++;
      $display("FAIL cause_hold got %b want %b", fault_cause, e.cause);
    end
  endtask

  task automatic test_ack_err();
    exp_q.push_back('{1, 2'b10, last_rd});
    run_op(0, 3'b010, 32'h100, 32'h0, 2, 1, 32'h11111111);
    e = exp_q.pop_front();
    n_cmp++;
    if (!o_fault || o_done || o_cause !== e.cause ||
        o_rdata !== e.rdata || o_req !== 2) begin
      n_err++;
      $display("FAIL ack_err got f=%0d d=%0d c=%b rd=%h req=%0d want 1 0 %b %h 2",
               o_fault, o_done, o_cause, o_rdata, o_req, e.cause, e.rdata);
    end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    mem_enable = 1; mem_rw_mode = 0;
    mem_func = 3'b010; addr = 32'h400;
    @(negedge clk);
    mem_enable = 0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.bus_req !== 1'b1 || stall !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_req got req=%b stall=%b want 1 1",
               bus.bus_req, stall);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.bus_req, stall, done, fault} !== 4'b0) begin
      n_err++;
      $display("FAIL async_reset got %b want 0000",
               {bus.bus_req, stall, done, fault});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({done, fault, bus.bus_req} !== 3'b0) begin
      n_err++;
      $display("FAIL post_reset got %b want 000",
               {done, fault, bus.bus_req});
    end
    exp_q.push_back('{0, 2'b00, 32'hCAFEF00D});
    run_op(0, 3'b010, 32'h404, 32'h0, 1, 0, 32'hCAFEF00D);
    e = exp_q.pop_front();
    n_cmp++;
    if (!o_done || o_rdata !== e.rdata || o_addr !== 32'h404) begin
      n_err++;
      $display("FAIL after_reset_lw got d=%0d rd=%h a=%h want 1 %h 404",
               o_done, o_rdata, o_addr, e.rdata);
    end
    last_rd = 32'hCAFEF00D;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  funcs[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  f;
    logic [31:0] a, rd;
    bit          rw;
    for (int i = 0; i < 8; i++) begin
      rw = ($urandom_range(0, 2) == 0);
      f  = rw ? funcs[$urandom_range(0, 2)]
              : funcs[$urandom_range(0, 4)];
      a  = $urandom;
      if (f[1:0] == 2'b01) a[0] = 1'b0;
      if (f[1:0] == 2'b10) a[1:0] = 2'b00;
      rd = $urandom;
      if (!rw) last_rd = model_load(f, a[1:0], rd);
      exp_q.push_back('{0, 2'b00, last_rd});
      run_op(rw, f, a, $urandom, $urandom_range(1, 3), 0, rd);
      e = exp_q.pop_front();
      n_cmp++;
      if (!o_done || o_fault || o_rdata !== e.rdata ||
          o_addr !== {a[31:2], 2'b00} || o_we !== rw) begin
        n_err++;
        $display("FAIL b2b[%0d] f=%b a=%h got d=%0d rd=%h ba=%h we=%b want rd=%h",
                 i, f, a, o_done, o_rdata, o_addr, o_we, e.rdata);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    last_rd = 32'h0;
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_faults();
    test_timeout();
    test_ack_err();
    test_reset_mid_req();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Multi-cycle load/store sequencer placed between the instruction decoder's memory controls and the external data bus. It accepts one decoded memory operation, drives a req/ack bus transaction, and generates byte-lane strobes and store-data replication. It sign- or zero-extends load data and stalls the core until the access completes. Misaligned addresses, illegal functions, bus errors and timeouts are reported as a one-cycle fault pulse.

## Interface
- TIMEOUT_CYCLES, 255: maximum REQ cycles without ack before a timeout fault; 0 disables the timeout.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_enable  in  1  decoded instruction is a memory access.
- mem_rw_mode  in  1  0 = load, 1 = store.
- mem_func  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  effective address (ALU result).
- wdata  in  32  store source (rs2 value).
- stall  out  1  hold PC and suppress register writeback.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result, registered.
- fault  out  1  one-cycle fault pulse.
- fault_cause  out  2  00 misaligned, 01 illegal func, 10 bus error, 11 timeout.
- bus_req  out  1  transaction request.
- bus_we  out  1  write enable.
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables.
- bus_ack  in  1  transaction complete.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_err  in  1  bus error, terminates the transaction.

## Operation
- States: IDLE, REQ, DONE, FAULT. Reset → IDLE.
- Legality checks:
  - Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Any other mem_func is illegal.
  - Alignment: H/HU require addr[0]=0; W requires addr[1:0]=00; B/BU accept any address.
- IDLE:
  - mem_enable=0: remain in IDLE.
  - Legal and aligned: latch bus_addr, bus_we, bus_be, bus_wdata, mem_func and addr[1:0]; go to REQ.
  - Illegal func: go to FAULT with cause 01. Misaligned: go to FAULT with cause 00. Illegal takes priority over misaligned.
- REQ:
  - bus_req=1; all bus outputs held stable.
  - bus_err: go to FAULT, cause 10. bus_err wins over a simultaneous bus_ack.
  - bus_ack: on a load, capture the extracted and extended lane into rdata; go to DONE.
  - Timeout counter increments each REQ cycle without a response. When it reaches TIMEOUT_CYCLES, go to FAULT with cause 11 (ack/err in that same cycle take priority over the timeout).
- DONE: done=1; go to IDLE.
- FAULT: fault=1 and fault_cause updated; go to IDLE. No bus transaction is issued for misaligned or illegal requests.
- Store lanes:
  - B: bus_be = 1 << addr[1:0]; bus_wdata = {4{wdata[7:0]}}.
  - H: bus_be = addr[1] ? 1100 : 0011; bus_wdata = {2{wdata[15:0]}}.
  - W: bus_be = 1111; bus_wdata = wdata.
- Loads: bus_be follows the same lane rule as stores; bus_wdata = 0.
- Load extraction:
  - Byte lane selected by addr[1:0]; half lane selected by addr[1].
  - 000/001 sign-extend; 100/101 zero-extend; 010 passes the word through.
- rdata holds its value until the next completed load; stores and faults leave it unchanged.
- fault_cause holds its value until the next fault.

## Timing
- stall = (IDLE & mem_enable) | REQ. It is combinational, so it is asserted in the decode cycle. stall=0 in DONE and FAULT, so the core advances on the edge ending DONE/FAULT.
- Latency: with ack on the first REQ cycle, the sequence is IDLE → REQ → DONE (3 cycles, stall high for 2). Each wait cycle adds one cycle.
- Reset values: stall 0 (mem_enable=0), done 0, fault 0, fault_cause 00, rdata 0, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_be 0, timeout counter 0.
- bus_req is decoded from the state register, so it drops asynchronously on rst_n low.
- Reset mid-REQ: transaction abandoned, no done or fault pulse; IDLE after release.
- The timeout counter clears on entry to REQ and never wraps (saturates at TIMEOUT_CYCLES).
- bus_ack/bus_err outside REQ are ignored.

## Test plan
- LW addr 0x100, ack on the 3rd REQ cycle with bus_rdata 0xDEADBEEF → bus_addr 0x100, be 1111, bus_we 0, stall high 4 cycles, done pulse, rdata 0xDEADBEEF.
- LB addr 0x203, bus_rdata 0x80FF1234 → rdata 0xFFFFFF80. LBU, same stimulus → 0x00000080. LHU addr 0x202 → 0x000080FF.
- SH addr 0x102, wdata 0x0000ABCD → bus_addr 0x100, be 1100, bus_wdata 0xABCDABCD, bus_we 1, done pulse, rdata unchanged.
- LW addr 0x102 → no bus_req, fault pulse, cause 00. Store with func 100 → cause 01.
- TIMEOUT_CYCLES=4, no ack → bus_req high 4 cycles, then fault with cause 11. bus_ack and bus_err asserted in the same cycle → cause 10, rdata unchanged.
- rst_n low in REQ → bus_req and stall drop immediately, no done pulse. After release, a new LW completes normally.
